// File: rtl/register_file.sv
// Purpose: 32 x 32-bit general-purpose register file, two combinational read ports and one write port, r0 reads zero.
// Latency: reads are zero-cycle (with same-cycle write bypass); writes commit at the rising clk edge.
// Backpressure: none; every write is accepted and the read ports are always valid.
module register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] read_reg_1,
    input  logic [ADDR_WIDTH-1:0] read_reg_2,
    input  logic [ADDR_WIDTH-1:0] write_reg,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  regWrite,
    output logic [DATA_WIDTH-1:0] read_data_1,
    output logic [DATA_WIDTH-1:0] read_data_2
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [DEPTH];

    // A write only counts when enabled and not aimed at r0. Held off
    // during reset so the bypass path cannot leak data while the array
    // is being forced to zero.
    logic wr_vld;
    assign wr_vld = regWrite && (write_reg != '0) && rst_n;

    // Per-port bypass hit: the port is reading the register WB is
    // writing this cycle, so it must see the incoming data now.
    logic bypass_1;
    logic bypass_2;
    assign bypass_1 = wr_vld && (read_reg_1 == write_reg);
    assign bypass_2 = wr_vld && (read_reg_2 == write_reg);

    // Storage: asynchronous clear of every entry, otherwise commit the
    // write on the rising edge. Entry 0 is never written after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_vld) begin
            regs[write_reg] <= write_data;
        end
    end

    // Read port 1: r0 always zero, reset forces zero regardless of the
    // array timing, bypass takes priority over the stored value.
    always_comb begin
        read_data_1 = '0;
        if (read_reg_1 == '0 || !rst_n) begin
            read_data_1 = '0;
        end else if (bypass_1) begin
            read_data_1 = write_data;
        end else begin
            read_data_1 = regs[read_reg_1];
        end
    end

    // Read port 2: same selection as port 1, fully independent.
    always_comb begin
        read_data_2 = '0;
        if (read_reg_2 == '0 || !rst_n) begin
            read_data_2 = '0;
        end else if (bypass_2) begin
            read_data_2 = write_data;
        end else begin
            read_data_2 = regs[read_reg_2];
        end
    end

endmodule

// File: tb/tb_register_file.sv
module tb_register_file;

    logic        clk;
    logic        rst_n;
    logic [4:0]  read_reg_1;
    logic [4:0]  read_reg_2;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic        regWrite;
    logic [31:0] read_data_1;
    logic [31:0] read_data_2;

    register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .read_reg_1  (read_reg_1),
        .read_reg_2  (read_reg_2),
        .write_reg   (write_reg),
        .write_data  (write_data),
        .regWrite    (regWrite),
        .read_data_1 (read_data_1),
        .read_data_2 (read_data_2)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    // Scoreboard: stimulus pushes expected values, monitor pops and compares.
    int          port_q [$];
    logic [31:0] exp_q  [$];
    string       name_q [$];
    logic        chk_req;
    logic        chk_ack;
    int          checks;
    int          errors;

    initial begin
        chk_ack = 1'b0;
        checks  = 0;
        errors  = 0;
        forever begin
            wait (chk_req);
            #1;
            while (exp_q.size() > 0) begin
                int          p;
                logic [31:0] e;
                logic [31:0] act;
                string       n;
                p   = port_q.pop_front();
                e   = exp_q.pop_front();
                n   = name_q.pop_front();
                act = (p == 0) ? read_data_1 : read_data_2;
                checks++;
                if (act !== e) begin
                    errors++;
                    $display("FAIL %s: port %0d got %h expected %h", n, p + 1, act, e);
                end
            end
            chk_ack = 1'b1;
            wait (!chk_req);
            chk_ack = 1'b0;
        end
    end

    task automatic check(input int port, input logic [4:0] addr, input logic [31:0] exp, input string name);
        if (port == 0) read_reg_1 = addr;
        else           read_reg_2 = addr;
        port_q.push_back(port);
        exp_q.push_back(exp);
        name_q.push_back(name);
        chk_req = 1'b1;
        for (int k = 0; k < 20 && !chk_ack; k++) #1;
        if (!chk_ack) begin
            $display("FAIL %s: monitor timeout, got no ack expected ack", name);
            $fatal(1);
        end
        chk_req = 1'b0;
        for (int k = 0; k < 20 && chk_ack; k++) #1;
    endtask

    task automatic sync();
        @(negedge clk);
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        sync();
        write_reg  = a;
        write_data = d;
        regWrite   = 1'b1;
        sync();
        regWrite   = 1'b0;
    endtask

    initial begin
        chk_req    = 1'b0;
        rst_n      = 1'b0;
        read_reg_1 = '0;
        read_reg_2 = '0;
        write_reg  = '0;
        write_data = '0;
        regWrite   = 1'b0;

        // Reset state
        #3;
        check(0, 5'd1,  32'h0, "reset_r1_p1");
        check(1, 5'd31, 32'h0, "reset_r31_p2");
        sync();
        rst_n = 1'b1;

        // Basic write/read
        wr(5'd1, 32'd55);
        check(1, 5'd1, 32'd55, "basic_r1_p2");
        check(0, 5'd0, 32'h0,  "basic_r0_p1");

        // Zero register: write ignored, no bypass for r0
        sync();
        write_reg  = 5'd0;
        write_data = 32'hDEADBEEF;
        regWrite   = 1'b1;
        check(0, 5'd0, 32'h0, "zero_before_edge");
        sync();
        regWrite = 1'b0;
        check(0, 5'd0, 32'h0, "zero_after_edge");

        // Bypass on both ports before the edge (r5 still 0 in storage)
        sync();
        write_reg  = 5'd5;
        write_data = 32'hA5A5A5A5;
        regWrite   = 1'b1;
        check(0, 5'd5, 32'hA5A5A5A5, "bypass_p1");
        check(1, 5'd5, 32'hA5A5A5A5, "bypass_p2");
        sync();
        regWrite = 1'b0;
        check(0, 5'd5, 32'hA5A5A5A5, "stored_p1");
        check(1, 5'd5, 32'hA5A5A5A5, "stored_p2");

        // Write disable: no bypass and no commit with regWrite low
        wr(5'd3, 32'd7);
        sync();
        write_reg  = 5'd3;
        write_data = 32'd9;
        regWrite   = 1'b0;
        check(0, 5'd3, 32'd7, "wdis_before_edge");
        sync();
        check(0, 5'd3, 32'd7, "wdis_after_edge");

        // Full sweep
        for (int i = 1; i < 32; i++) begin
            wr(i[4:0], i * 32'h01010101);
        end
        for (int i = 0; i < 32; i++) begin
            sync();
            check(0, i[4:0], i * 32'h01010101, "sweep_p1");
            check(1, i[4:0], i * 32'h01010101, "sweep_p2");
        end

        // Asynchronous reset mid-cycle, then a write held through reset is lost
        sync();
        #2;
        rst_n = 1'b0;
        check(0, 5'd1,  32'h0, "areset_r1_p1");
        check(1, 5'd1,  32'h0, "areset_r1_p2");
        sync();
        check(0, 5'd17, 32'h0, "areset_r17_p1");
        check(1, 5'd17, 32'h0, "areset_r17_p2");
        sync();
        check(0, 5'd31, 32'h0, "areset_r31_p1");
        check(1, 5'd31, 32'h0, "areset_r31_p2");
        write_reg  = 5'd17;
        write_data = 32'h12345678;
        regWrite   = 1'b1;
        check(0, 5'd17, 32'h0, "reset_no_bypass");
        sync();
        sync();
        regWrite = 1'b0;
        rst_n    = 1'b1;
        sync();
        check(0, 5'd17, 32'h0, "write_lost_in_reset");
        check(1, 5'd31, 32'h0, "post_reset_r31");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
